// File: rtl/mod_arith_pkg.sv
// Shared constants and helpers for the modular arithmetic datapath.
// Mode encodings, default moduli and the extended-width helper.
package mod_arith_pkg;

    localparam logic [1:0] MODE_MADD = 2'b00;
    localparam logic [1:0] MODE_MSUB = 2'b01;
    localparam logic [1:0] MODE_RADD = 2'b10;
    localparam logic [1:0] MODE_RSUB = 2'b11;

    localparam int Q_KYBER     = 3329;
    localparam int Q_DILITHIUM = 8380417;

    function automatic int ext_w(input int w);
        return w + 1;
    endfunction

endpackage

// File: rtl/mod_correct.sv
// Single-step modular correction of an extended add/sub value.
// Purely combinational; shared with the multiplier's final reduction.
module mod_correct
    import mod_arith_pkg::*;
#(
    parameter int width = 12
) (
    input  logic [width:0]   r,
    input  logic [1:0]       mode,
    input  logic [width-1:0] q,
    output logic [width-1:0] result
);

    logic             ge_q;
    logic [width-1:0] diff;
    logic [width-1:0] wrap;

    assign ge_q = r >= {1'b0, q};
    assign diff = r[width-1:0] - q;
    assign wrap = r[width-1:0] + q;

    always_comb begin
        result = r[width-1:0];
        unique case (mode)
            MODE_MADD: result = ge_q ? diff : r[width-1:0];
            // r[width] is the no-borrow flag for subtraction
            MODE_MSUB: result = r[width] ? r[width-1:0] : wrap;
            default:   result = r[width-1:0];
        endcase
    end

endmodule

// File: rtl/mod_add_sub_pipe.sv
// Two-stage modular / raw adder-subtractor with valid/ready handshake.
// Stage 1 forms the extended sum, stage 2 applies one correction.
module mod_add_sub_pipe
    import mod_arith_pkg::*;
#(
    parameter int width   = 12,
    parameter int modulus = Q_KYBER,
    parameter int tag_w   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] operand_1,
    input  logic [width-1:0] operand_2,
    input  logic [1:0]       mode,
    input  logic [tag_w-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] result,
    output logic [tag_w-1:0] out_tag
);

    localparam int ew = ext_w(width);
    localparam logic [width-1:0] q_val = width'(modulus);

    logic             s1_valid;
    logic [ew-1:0]    s1_r;
    logic             s1_sub;
    logic             s1_raw;
    logic [tag_w-1:0] s1_tag;

    logic             s2_valid;
    logic [width-1:0] s2_result;
    logic [tag_w-1:0] s2_tag;

    logic             s1_load;
    logic             s2_load;
    logic [width-1:0] b_sel;
    logic [ew-1:0]    r_next;
    logic [width-1:0] corr;

    assign s2_load  = !s2_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    // Subtraction as a + ~b + 1 leaves the no-borrow flag in the MSB
    assign b_sel  = mode[0] ? ~operand_2 : operand_2;
    assign r_next = {1'b0, operand_1} + {1'b0, b_sel} + ew'(mode[0]);

    mod_correct #(
        .width(width)
    ) u_correct (
        .r     (s1_r),
        .mode  ({s1_raw, s1_sub}),
        .q     (q_val),
        .result(corr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_r      <= '0;
            s1_sub    <= 1'b0;
            s1_raw    <= 1'b0;
            s1_tag    <= '0;
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_tag    <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid <= in_valid;
            end
            if (in_valid && s1_load) begin
                s1_r   <= r_next;
                s1_sub <= mode[0];
                s1_raw <= mode[1];
                s1_tag <= in_tag;
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
            end
            if (s1_valid && s2_load) begin
                s2_result <= corr;
                s2_tag    <= s1_tag;
            end
        end
    end

    assign out_valid = s2_valid;
    assign result    = s2_result;
    assign out_tag   = s2_tag;

endmodule

// File: tb/tb_mod_add_sub_pipe.sv
// Directed bench for mod_add_sub_pipe (width 12, q 3329).
// Vector table plus backpressure, flush and async reset sequences.
module tb_mod_add_sub_pipe;

    localparam int W  = 12;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  operand_1;
    logic [W-1:0]  operand_2;
    logic [1:0]    mode;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic [TW-1:0] out_tag;

    int total = 0;
    int bad   = 0;

    mod_add_sub_pipe #(
        .width  (W),
        .modulus(3329),
        .tag_w  (TW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .operand_1(operand_1),
        .operand_2(operand_2),
        .mode     (mode),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .out_tag  (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned a;
        int unsigned b;
        logic [1:0]  m;
        int unsigned exp;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input int unsigned act,
                       input int unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nacc;
        int nout;
        int first_c;
        int last_c;
        logic [W-1:0]  held_res;
        logic [TW-1:0] held_tag;
        logic acc;

        vecs[0]  = '{3000, 500,  2'b00, 171};
        vecs[1]  = '{5,    10,   2'b01, 3324};
        vecs[2]  = '{3328, 3328, 2'b00, 3327};
        vecs[3]  = '{0,    0,    2'b01, 0};
        vecs[4]  = '{3328, 1,    2'b00, 0};
        vecs[5]  = '{4095, 1,    2'b10, 0};
        vecs[6]  = '{0,    1,    2'b11, 4095};
        vecs[7]  = '{100,  30,   2'b01, 70};
        vecs[8]  = '{1000, 2000, 2'b00, 3000};
        vecs[9]  = '{3328, 0,    2'b01, 3328};
        vecs[10] = '{3328, 3328, 2'b10, 2560};
        vecs[11] = '{10,   3,    2'b11, 7};
        vecs[12] = '{0,    3328, 2'b01, 1};
        vecs[13] = '{4000, 4000, 2'b00, 575};

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        operand_1 = '0;
        operand_2 = '0;
        mode      = 2'b00;
        in_tag    = '0;
        out_ready = 1'b1;

        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_out_tag", out_tag, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", in_ready, 1);

        // single beats: latency and value per vector
        for (int i = 0; i < 14; i++) begin
            out_ready = 1'b1;
            in_valid  = 1'b1;
            operand_1 = W'(vecs[i].a);
            operand_2 = W'(vecs[i].b);
            mode      = vecs[i].m;
            in_tag    = TW'(i + 16);
            #1;
            chk($sformatf("v%0d_in_ready", i), in_ready, 1);
            tick();
            in_valid = 1'b0;
            chk($sformatf("v%0d_lat1", i), out_valid, 0);
            tick();
            chk($sformatf("v%0d_valid", i), out_valid, 1);
            chk($sformatf("v%0d_result", i), result, vecs[i].exp);
            chk($sformatf("v%0d_tag", i), out_tag, i + 16);
        end
        tick();
        chk("drain_empty", out_valid, 0);

        // backpressure: 6 beats, out_ready low for 4 cycles
        nacc    = 0;
        nout    = 0;
        first_c = -1;
        last_c  = -1;
        held_res = '0;
        held_tag = '0;
        for (int c = 0; c < 20; c++) begin
            out_ready = (c >= 4);
            in_valid  = (nacc < 6);
            operand_1 = W'((nacc + 1) * 100);
            operand_2 = W'(nacc + 1);
            mode      = 2'b00;
            in_tag    = TW'(nacc + 1);
            #1;
            if (c == 2) begin
                chk("bp_in_ready_low", in_ready, 0);
                chk("bp_out_valid", out_valid, 1);
                held_res = result;
                held_tag = out_tag;
            end
            if (c == 3) begin
                chk("bp_hold_result", result, held_res);
                chk("bp_hold_tag", out_tag, held_tag);
                chk("bp_hold_value", result, 101);
            end
            if (out_valid && out_ready) begin
                chk($sformatf("bp_tag%0d", nout), out_tag, nout + 1);
                chk($sformatf("bp_res%0d", nout), result, (nout + 1) * 101);
                if (first_c < 0) first_c = c;
                last_c = c;
                nout++;
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) nacc++;
        end
        in_valid = 1'b0;
        chk("bp_count", nout, 6);
        chk("bp_first", first_c, 4);
        chk("bp_rate", last_c - first_c, 5);

        // flush with both stages full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        mode      = 2'b00;
        operand_1 = W'(7);
        operand_2 = W'(8);
        in_tag    = 8'hA1;
        tick();
        in_tag = 8'hA2;
        tick();
        chk("fl_full", out_valid, 1);
        in_tag = 8'hA3;
        flush  = 1'b1;
        tick();
        chk("fl_clear", out_valid, 0);
        out_ready = 1'b1;
        in_tag    = 8'hA4;
        #1;
        chk("fl_in_ready", in_ready, 1);
        tick();
        chk("fl_discard", out_valid, 0);
        flush     = 1'b0;
        operand_1 = W'(20);
        operand_2 = W'(22);
        in_tag    = 8'hB0;
        tick();
        in_valid = 1'b0;
        chk("fl_next_lat1", out_valid, 0);
        tick();
        chk("fl_next_valid", out_valid, 1);
        chk("fl_next_tag", out_tag, 8'hB0);
        chk("fl_next_result", result, 42);
        tick();
        chk("fl_no_ghost", out_valid, 0);

        // async reset between edges
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tag    = 8'hC1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("ar_pre_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid_clr", out_valid, 0);
        chk("ar_result_clr", result, 0);
        chk("ar_tag_clr", out_tag, 0);
        tick();
        #3;
        rst_n = 1'b1;
        #1;
        chk("ar_in_ready", in_ready, 1);
        tick();
        chk("ar_no_out1", out_valid, 0);
        tick();
        chk("ar_no_out2", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
